// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbiter states and the
// request bundle used for the cpu, debug and memory sides.
package dmem_arbiter_pkg;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
        logic [2:0]         funct3;
    } dmem_req_t;

    localparam dmem_req_t REQ_IDLE = '0;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the arbiter: MEM-stage request, debug port and
// the datamemory port. slave = arbiter side, master = environment side.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [DM_ADDRESS-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [2:0]            cpu_funct3;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_stall;

    logic                  dbg_valid;
    logic                  dbg_we;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic [2:0]            dbg_funct3;
    logic                  dbg_ready;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_funct3,
        output cpu_rdata, cpu_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_funct3,
        input  cpu_rdata, cpu_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive cycles the debug port is blocked by the CPU;
// o_expire flags the last tolerated blocked cycle.
module starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);
    localparam logic [W-1:0] SAT  = W'(MAX_WAIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && r_cnt != SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority)
// and the debug/loader port, with a forced debug slot on starvation.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = DMEM_AW,
    parameter int DATA_W     = DMEM_DW,
    parameter int MAX_WAIT   = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [0:0] ST_CPU   = ARB_CPU;
    localparam logic [0:0] ST_FORCE = ARB_FORCE;

    logic [0:0]            r_state;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    dmem_req_t             w_cpu;
    dmem_req_t             w_dbg;
    dmem_req_t             w_mem;
    logic                  w_in_force;
    logic                  w_cpu_req;
    logic                  w_gnt_cpu;
    logic                  w_gnt_dbg;
    logic                  w_blocked;
    logic                  w_expire;
    logic                  w_rd_acc;
    logic [DM_ADDRESS-1:0] w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;

    assign w_cpu = '{rd: bus.cpu_rd, wr: bus.cpu_wr,
                     addr: bus.cpu_addr, wdata: bus.cpu_wdata,
                     funct3: bus.cpu_funct3};
    assign w_dbg = '{rd: ~bus.dbg_we, wr: bus.dbg_we,
                     addr: bus.dbg_addr, wdata: bus.dbg_wdata,
                     funct3: bus.dbg_funct3};

    assign w_in_force = (r_state == ST_FORCE);
    assign w_cpu_req  = bus.cpu_rd | bus.cpu_wr;
    assign w_gnt_cpu  = ~w_in_force & w_cpu_req;
    // Debug grant is masked while reset is held so dbg_ready drops at once.
    assign w_gnt_dbg  = ~reset & bus.dbg_valid & (w_in_force | ~w_cpu_req);
    assign w_blocked  = ~w_in_force & w_cpu_req & bus.dbg_valid;
    assign w_rd_acc   = w_gnt_dbg & ~bus.dbg_we;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (~w_blocked),
        .i_inc    (w_blocked),
        .o_expire (w_expire)
    );

    always_comb begin
        w_mem = REQ_IDLE;
        unique case (1'b1)
            w_gnt_cpu: w_mem = w_cpu;
            w_gnt_dbg: w_mem = w_dbg;
            default:   w_mem = REQ_IDLE;
        endcase
    end

    assign w_mem_addr     = w_mem.addr;
    assign w_mem_wdata    = w_mem.wdata;
    assign bus.mem_rd     = w_mem.rd;
    assign bus.mem_wr     = w_mem.wr;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_funct3 = w_mem.funct3;

    assign bus.cpu_rdata  = w_in_force ? '0 : bus.mem_rdata;
    assign bus.cpu_stall  = w_in_force;
    assign bus.dbg_ready  = w_gnt_dbg;
    assign bus.dbg_rvalid = r_rvalid;
    assign bus.dbg_rdata  = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CPU;
        end else if (w_in_force) begin
            r_state <= ST_CPU;
        end else if (w_blocked && w_expire) begin
            r_state <= ST_FORCE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a cycle-level ownership model
// checked every cycle plus directed literal expectations.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [31:0] tb_mem [0:511];

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the memory port this cycle, from blocked-cycle count.
    int          m_blocked;
    bit          m_force;
    bit          m_pv;
    logic [31:0] m_rd;

    initial begin
        m_blocked = 0;
        m_force   = 0;
        m_pv      = 0;
        m_rd      = '0;
    end

    always @(negedge clk) begin
        bit          cpu_req;
        bit          force_now;
        logic        e_rd, e_wr, e_stall, e_ready;
        logic [8:0]  e_addr;
        logic [31:0] e_wdata, e_crd;
        logic [2:0]  e_f3;

        cpu_req   = bus.cpu_rd | bus.cpu_wr;
        force_now = m_force && !reset;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_f3 = '0;
        e_stall = 0; e_ready = 0;
        if (force_now) begin
            e_stall = 1;
            if (bus.dbg_valid) begin
                e_ready = 1;
                e_rd = !bus.dbg_we; e_wr = bus.dbg_we;
                e_addr = bus.dbg_addr; e_wdata = bus.dbg_wdata;
                e_f3 = bus.dbg_funct3;
            end
        end else if (cpu_req) begin
            e_rd = bus.cpu_rd; e_wr = bus.cpu_wr;
            e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
            e_f3 = bus.cpu_funct3;
        end else if (!reset && bus.dbg_valid) begin
            e_ready = 1;
            e_rd = !bus.dbg_we; e_wr = bus.dbg_we;
            e_addr = bus.dbg_addr; e_wdata = bus.dbg_wdata;
            e_f3 = bus.dbg_funct3;
        end
        e_crd = force_now ? 32'h0 : tb_mem[e_addr];

        chk("cyc_mem_rd", bus.mem_rd, e_rd);
        chk("cyc_mem_wr", bus.mem_wr, e_wr);
        chk("cyc_mem_addr", bus.mem_addr, e_addr);
        chk("cyc_mem_wdata", bus.mem_wdata, e_wdata);
        chk("cyc_mem_funct3", bus.mem_funct3, e_f3);
        chk("cyc_cpu_stall", bus.cpu_stall, e_stall);
        chk("cyc_dbg_ready", bus.dbg_ready, e_ready);
        chk("cyc_cpu_rdata", bus.cpu_rdata, e_crd);
        chk("cyc_dbg_rvalid", bus.dbg_rvalid, reset ? 1'b0 : m_pv);
        chk("cyc_dbg_rdata", bus.dbg_rdata, reset ? 32'h0 : m_rd);

        if (reset) begin
            m_blocked = 0; m_force = 0; m_pv = 0; m_rd = '0;
        end else begin
            m_pv = e_ready && !bus.dbg_we;
            if (m_pv) m_rd = tb_mem[bus.dbg_addr];
            if (!m_force && cpu_req && bus.dbg_valid) begin
                m_blocked++;
                m_force = (m_blocked >= MAX_WAIT);
                if (m_force) m_blocked = 0;
            end else begin
                m_blocked = 0;
                m_force   = 0;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 512; i++) tb_mem[i] <= '0;
        reset = 1;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_funct3 = '0;
        bus.dbg_valid = 0; bus.dbg_we = 0; bus.dbg_addr = '0;
        bus.dbg_wdata = '0; bus.dbg_funct3 = '0;
        repeat (3) tick();
        #3;
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_ready", bus.dbg_ready, 0);
        chk("rst_rvalid", bus.dbg_rvalid, 0);
        chk("rst_rdata", bus.dbg_rdata, 0);
        tick();
        reset = 0;

        // Debug writes then read-back while CPU idle
        bus.dbg_valid = 1; bus.dbg_we = 1; bus.dbg_addr = 9'h010;
        bus.dbg_wdata = 32'hDEADBEEF; bus.dbg_funct3 = 3'd2;
        #3;
        chk("dw_ready", bus.dbg_ready, 1);
        chk("dw_mem_wr", bus.mem_wr, 1);
        chk("dw_mem_addr", bus.mem_addr, 32'h010);
        tick();
        bus.dbg_addr = 9'h011; bus.dbg_wdata = 32'hA5A50011;
        tick();
        bus.dbg_we = 0; bus.dbg_addr = 9'h010;
        #3;
        chk("dr_ready", bus.dbg_ready, 1);
        chk("dr_mem_rd", bus.mem_rd, 1);
        tick();
        bus.dbg_valid = 0;
        #3;
        chk("dr_rvalid", bus.dbg_rvalid, 1);
        chk("dr_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        tick();
        #3;
        chk("dr_rvalid_off", bus.dbg_rvalid, 0);
        chk("dr_rdata_hold", bus.dbg_rdata, 32'hDEADBEEF);
        tick();

        // Starvation under continuous CPU loads
        bus.cpu_rd = 1; bus.cpu_addr = 9'h011; bus.cpu_funct3 = 3'd2;
        bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 9'h010;
        for (int i = 0; i < 8; i++) begin
            #3;
            chk("st_ready_lo", bus.dbg_ready, 0);
            chk("st_stall_lo", bus.cpu_stall, 0);
            chk("st_cpu_rdata", bus.cpu_rdata, 32'hA5A50011);
            tick();
        end
        #3;
        chk("st_force_stall", bus.cpu_stall, 1);
        chk("st_force_ready", bus.dbg_ready, 1);
        chk("st_force_rdata0", bus.cpu_rdata, 0);
        chk("st_force_addr", bus.mem_addr, 32'h010);
        tick();
        bus.dbg_valid = 0;
        #3;
        chk("st_back_stall", bus.cpu_stall, 0);
        chk("st_back_addr", bus.mem_addr, 32'h011);
        chk("st_back_rvalid", bus.dbg_rvalid, 1);
        chk("st_back_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        tick();
        bus.cpu_rd = 0;
        tick();

        // CPU stores in bursts of 7; debug reads only in idle gaps
        bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 9'h020;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 7; j++) begin
                bus.cpu_wr = 1; bus.cpu_addr = 9'h020;
                bus.cpu_wdata = 32'h12345678 + r; bus.cpu_funct3 = 3'd2;
                #3;
                chk("alt_ready_lo", bus.dbg_ready, 0);
                chk("alt_stall_lo", bus.cpu_stall, 0);
                if (j == 0 && r > 0) begin
                    chk("alt_rvalid", bus.dbg_rvalid, 1);
                    chk("alt_rdata", bus.dbg_rdata, 32'h12345678 + r - 1);
                end
                tick();
            end
            bus.cpu_wr = 0;
            #3;
            chk("alt_ready_hi", bus.dbg_ready, 1);
            chk("alt_mem_rd", bus.mem_rd, 1);
            tick();
        end
        bus.dbg_valid = 0;
        #3;
        chk("alt_rvalid_last", bus.dbg_rvalid, 1);
        chk("alt_rdata_last", bus.dbg_rdata, 32'h1234567A);
        tick();

        // dbg_valid dropped during the forced slot
        bus.cpu_rd = 1; bus.cpu_addr = 9'h011;
        bus.dbg_valid = 1; bus.dbg_addr = 9'h010;
        repeat (8) tick();
        bus.dbg_valid = 0;
        #3;
        chk("drop_stall", bus.cpu_stall, 1);
        chk("drop_mem_rd", bus.mem_rd, 0);
        chk("drop_mem_wr", bus.mem_wr, 0);
        chk("drop_ready", bus.dbg_ready, 0);
        tick();
        #3;
        chk("drop_rvalid", bus.dbg_rvalid, 0);
        chk("drop_stall_off", bus.cpu_stall, 0);
        tick();

        // Reset asserted in the middle of a forced slot
        bus.dbg_valid = 1;
        repeat (8) tick();
        #1;
        chk("rf_stall_pre", bus.cpu_stall, 1);
        reset = 1;
        #1;
        chk("rf_stall", bus.cpu_stall, 0);
        chk("rf_ready", bus.dbg_ready, 0);
        chk("rf_rvalid", bus.dbg_rvalid, 0);
        chk("rf_mem_rd", bus.mem_rd, 1);
        tick();
        #3;
        chk("rf_rvalid_post", bus.dbg_rvalid, 0);
        chk("rf_stall_post", bus.cpu_stall, 0);
        reset = 0;
        tick();
        bus.cpu_rd = 0; bus.dbg_valid = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
